// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the game control unit: state codes, board timing defaults,
// and the timer width helper.
package unidade_controle_pkg;

  typedef enum logic [3:0] {
    Inicial  = 4'd0,
    Prepara  = 4'd1,
    Jogando  = 4'd2,
    Comemora = 4'd3,
    Proximo  = 4'd4,
    Carrega  = 4'd5,
    Vitoria  = 4'd6,
    Derrota  = 4'd7
  } estado_t;

  // One-second celebration at 50 MHz; no per-level time limit by default.
  localparam int unsigned PausaCiclosPadrao   = 50_000_000;
  localparam int unsigned TimeoutCiclosPadrao = 0;

  function automatic int unsigned largura_timer(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/temporizador_ciclos.sv
// Saturating cycle counter with synchronous clear; fim flags count == N-1.
// With N = 0 the counter just saturates and fim never asserts.
module temporizador_ciclos
  import unidade_controle_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned W = largura_timer(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic         fim,
  output logic [W-1:0] Q
);

  localparam logic [W-1:0] Limite = (N == 0) ? {W{1'b1}} : W'(N - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Q <= '0;
    end else if (zera) begin
      Q <= '0;
    end else if (conta && (Q != Limite)) begin
      Q <= Q + W'(1);
    end
  end

  assign fim = (N != 0) && (Q == Limite);

endmodule

// File: rtl/unidade_controle.sv
// Game control FSM: sequences start, play, celebration pause, level advance,
// victory and timeout defeat. All outputs are decoded from the state register only.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int unsigned PAUSA_CICLOS   = PausaCiclosPadrao,
  parameter int unsigned TIMEOUT_CICLOS = TimeoutCiclosPadrao
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       nivel_concluido,
  input  logic       nivelIgualUltimoNivel,
  output logic       contaN,
  output logic       zeraN,
  output logic       zeraM,
  output logic       pronto,
  output logic       jogando,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  estado_t estado_q, estado_d;

  logic fim_pausa, fim_timeout;
  logic zera_pausa, conta_pausa, zera_timeout, conta_timeout;
  logic [largura_timer(PAUSA_CICLOS)-1:0]   q_pausa;
  logic [largura_timer(TIMEOUT_CICLOS)-1:0] q_timeout;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= Inicial;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      Inicial:  if (iniciar) estado_d = Prepara;
      Prepara:  estado_d = Jogando;
      Jogando: begin
        // A solved level wins over a timeout landing on the same cycle.
        if (nivel_concluido) begin
          estado_d = Comemora;
        end else if ((TIMEOUT_CICLOS != 0) && fim_timeout) begin
          estado_d = Derrota;
        end
      end
      Comemora: begin
        if (fim_pausa) estado_d = nivelIgualUltimoNivel ? Vitoria : Proximo;
      end
      Proximo:  estado_d = Carrega;
      Carrega:  estado_d = Jogando;
      Vitoria:  if (iniciar) estado_d = Prepara;
      Derrota:  if (iniciar) estado_d = Prepara;
      default:  estado_d = Inicial;
    endcase
  end

  always_comb begin
    contaN        = 1'b0;
    zeraN         = 1'b0;
    zeraM         = 1'b0;
    pronto        = 1'b0;
    jogando       = 1'b0;
    ganhou        = 1'b0;
    perdeu        = 1'b0;
    zera_timeout  = 1'b0;
    conta_timeout = 1'b0;
    conta_pausa   = 1'b0;
    case (estado_q)
      Inicial: begin
        zeraN  = 1'b1;
        zeraM  = 1'b1;
        pronto = 1'b1;
      end
      Prepara: begin
        zeraN        = 1'b1;
        zeraM        = 1'b1;
        zera_timeout = 1'b1;
      end
      Jogando: begin
        jogando       = 1'b1;
        conta_timeout = 1'b1;
      end
      Comemora: conta_pausa = 1'b1;
      Proximo: begin
        contaN = 1'b1;
        zeraM  = 1'b1;
      end
      Carrega: begin
        zeraM        = 1'b1;
        zera_timeout = 1'b1;
      end
      Vitoria: ganhou = 1'b1;
      Derrota: perdeu = 1'b1;
      default: ;
    endcase
  end

  // The pause timer restarts from zero every time COMEMORA is entered.
  assign zera_pausa = !conta_pausa;
  assign db_estado  = estado_q;

  temporizador_ciclos #(
    .N(PAUSA_CICLOS)
  ) u_pausa (
    .clock(clock),
    .reset(reset),
    .zera (zera_pausa),
    .conta(conta_pausa),
    .fim  (fim_pausa),
    .Q    (q_pausa)
  );

  temporizador_ciclos #(
    .N(TIMEOUT_CICLOS)
  ) u_timeout (
    .clock(clock),
    .reset(reset),
    .zera (zera_timeout),
    .conta(conta_timeout),
    .fim  (fim_timeout),
    .Q    (q_timeout)
  );

  logic unused_q;
  assign unused_q = ^{q_pausa, q_timeout};

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Game control FSM that sits directly upstream of the datapath.
- Drives the datapath's control inputs: contaN (level counter enable), zeraN (level counter clear) and zeraM (LED-matrix/edge-detector reset).
- Consumes the datapath status: nivel_concluido and nivelIgualUltimoNivel.
- Sequences the game: idle, start, play level, celebration pause, advance level, then victory after the last level (3'b101) or defeat on timeout.

Parameters:
- PAUSA_CICLOS, 50_000_000, length of the celebration pause in cycles after a level is completed; must be >= 1.
- TIMEOUT_CICLOS, 0, maximum cycles allowed per level in JOGANDO; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  start/restart request, level-sensitive, already edge-detected upstream
- nivel_concluido  in  1  current level solved, from datapath
- nivelIgualUltimoNivel  in  1  level counter == 5, from datapath
- contaN  out  1  increment level counter (active-high, one cycle)
- zeraN  out  1  clear level counter (active-high)
- zeraM  out  1  reset matrix and edge detector (active-high)
- pronto  out  1  high in INICIAL
- jogando  out  1  high in JOGANDO
- ganhou  out  1  high in VITORIA
- perdeu  out  1  high in DERROTA
- db_estado  out  4  current state code, for debug

Behaviour:
- Moore FSM. All outputs are decoded only from the state register; no input-to-output combinational path.
- Reset low (asynchronous): state = INICIAL, both timers = 0. Output values while and just after reset are those of INICIAL:
  - zeraN=1, zeraM=1, pronto=1
  - contaN=0, jogando=0, ganhou=0, perdeu=0
  - db_estado=0
- Reset released mid-game: restart from INICIAL. No partial state is kept.
- State codes and transitions, evaluated at each rising clock edge:
  - INICIAL (0): zeraN=1, zeraM=1, pronto=1. iniciar=1 -> PREPARA.
  - PREPARA (1): zeraN=1, zeraM=1 for exactly 1 cycle; clear the timeout timer. -> JOGANDO.
  - JOGANDO (2): jogando=1. Timeout timer counts up by 1 per cycle.
    - nivel_concluido=1 -> COMEMORA. This takes priority over timeout in the same cycle.
    - Else, if TIMEOUT_CICLOS != 0 and timer == TIMEOUT_CICLOS-1 -> DERROTA.
  - COMEMORA (3): all control outputs 0, so the matrix keeps showing the solved pattern. Pause timer counts from 0. When timer == PAUSA_CICLOS-1:
    - nivelIgualUltimoNivel=1 -> VITORIA.
    - Otherwise -> PROXIMO.
    - Dwell is exactly PAUSA_CICLOS cycles.
  - PROXIMO (4): contaN=1, zeraM=1 for exactly 1 cycle. -> CARREGA.
  - CARREGA (5): zeraM=1 for 1 cycle, so the matrix reloads with the updated level. Clear the timeout timer. -> JOGANDO.
  - VITORIA (6): ganhou=1. iniciar=1 -> PREPARA.
  - DERROTA (7): perdeu=1. iniciar=1 -> PREPARA.
- iniciar is ignored in PREPARA, JOGANDO, COMEMORA, PROXIMO and CARREGA.
- nivel_concluido is ignored outside JOGANDO.
- nivelIgualUltimoNivel is sampled only on the last COMEMORA cycle.
- contaN is asserted at most once per completed level. The counter therefore never exceeds 5 from this block's stimulus.
- Latency:
  - iniciar in INICIAL to jogando=1: 2 cycles.
  - nivel_concluido to next-level jogando=1: PAUSA_CICLOS+2 cycles (COMEMORA for PAUSA_CICLOS cycles, then PROXIMO, then CARREGA, then JOGANDO).
- Timer widths: $clog2(max(PARAM,2)) bits each.
  - Timers must never wrap within a dwell.
  - The timeout timer saturates when TIMEOUT_CICLOS=0.
- Unused codes 8-15: return to INICIAL on the next edge.

Decomposition:
- Shared package: state encoding constants (INICIAL..DERROTA, 4-bit), and the default PAUSA_CICLOS/TIMEOUT_CICLOS values for the 50 MHz board.
- One sub-module, temporizador_ciclos:
  - Parameter N; inputs clock, reset (active-low, async), zera, conta; outputs fim (count == N-1) and Q.
  - Instantiated twice: pause timer and timeout timer.
- The FSM (state register, next-state logic, output decode) lives in unidade_controle.

Test Plan:
- Reset: assert reset=0 mid-COMEMORA -> state immediately INICIAL, db_estado=0, zeraN=1, zeraM=1, pronto=1, timers 0.
- Start: PAUSA_CICLOS=4. Pulse iniciar for 1 cycle in INICIAL -> PREPARA for 1 cycle (zeraN=1), then jogando=1 on the 2nd edge.
- Level advance: in JOGANDO pulse nivel_concluido with nivelIgualUltimoNivel=0 -> exactly 4 cycles of COMEMORA, then a single-cycle contaN=1 with zeraM=1, then CARREGA zeraM=1, then jogando=1. Total 6 cycles.
- Victory: run the full game, pulsing nivel_concluido 6 times with a datapath model (levels 0..5) -> after the 6th pause ganhou=1, contaN pulses counted = 5. Then iniciar -> PREPARA with zeraN=1.
- Timeout: TIMEOUT_CICLOS=10, no nivel_concluido -> perdeu=1 exactly 10 cycles after entering JOGANDO. A nivel_concluido on cycle 10 instead -> COMEMORA (priority check).
- Ignored inputs: iniciar held high through JOGANDO/COMEMORA -> no state change. nivel_concluido in VITORIA -> no effect.
